// File: rtl/twiddle_cmult.sv
// Complex multiply of framed samples by Q1.(CW-2) twiddles; 3-stage pipeline, round half up.
// Define CMULT_SAT_EN to clamp out-of-range results; otherwise they wrap to DW bits.
module twiddle_cmult #(
   parameter int unsigned DW   = 16,
   parameter int unsigned CW   = 11,
   parameter int unsigned SIZE = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [2*DW-1:0]   in_data,
   input  logic [2*CW-1:0]   coeff_in,
   output logic              out_valid,
   output logic              out_sof,
   output logic              out_eof,
   output logic [2*DW-1:0]   out_data,
   output logic              frame_err,
   output logic              ovf
);

   localparam int unsigned IdxW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned PW   = DW + CW;
   localparam int unsigned FW   = DW + CW + 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(SIZE - 1);
   localparam logic signed [FW-1:0] RndAdd = FW'(2 ** (CW - 3));

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d, cur_idx;
   logic            accept, restart, last, frame_err_set;

   logic                   s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
   logic signed [DW-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic signed [CW-1:0]   s1_c_q, s1_c_d, s1_d_q, s1_d_d;
   logic                   s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;
   logic signed [PW-1:0]   p_ac_q, p_ac_d, p_bd_q, p_bd_d, p_ad_q, p_ad_d, p_bc_q, p_bc_d;
   logic                   out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
   logic [2*DW-1:0]        out_data_q, out_data_d;
   logic                   frame_err_q, frame_err_d, ovf_q, ovf_d;
   logic signed [FW-1:0]   sum_re, sum_im;
   logic [DW:0]            lim_re, lim_im;

   // Returns {out_of_range, result} for a pre-rounded full-precision sum.
   function automatic logic [DW:0] limit(input logic signed [FW-1:0] s);
      logic signed [FW-1:0] sh;
      logic                 oor;
      logic [DW-1:0]        r;
      sh  = s >>> (CW - 2);
      oor = !((&sh[FW-1:DW-1]) | ~(|sh[FW-1:DW-1]));
`ifdef CMULT_SAT_EN
      if (oor) begin
         r = sh[FW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         r = sh[DW-1:0];
      end
`else
      r = sh[DW-1:0];
`endif
      return {oor, r};
   endfunction

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // FSM outputs: acceptance and frame position of the current input
   always_comb begin
      accept        = 1'b0;
      restart       = 1'b0;
      frame_err_set = 1'b0;
      unique case (state_q)
         StIdle: accept = in_valid & in_sof;
         StRun: begin
            accept        = in_valid;
            restart       = in_valid & in_sof;
            frame_err_set = restart & (idx_q != '0);
         end
         default: ;
      endcase
      cur_idx = ((state_q == StIdle) || restart) ? '0 : idx_q;
      last    = accept & (cur_idx == LastIdx);
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (accept) begin
         if (last) begin
            state_d = StIdle;
            idx_d   = '0;
         end else begin
            state_d = StRun;
            idx_d   = cur_idx + IdxW'(1);
         end
      end
   end

   always_comb begin
      s1_valid_d  = accept;
      s1_sof_d    = accept & in_sof;
      s1_eof_d    = last;
      s1_a_d      = in_data[2*DW-1:DW];
      s1_b_d      = in_data[DW-1:0];
      s1_c_d      = coeff_in[2*CW-1:CW];
      s1_d_d      = coeff_in[CW-1:0];
      frame_err_d = frame_err_q | frame_err_set;

      s2_valid_d  = s1_valid_q;
      s2_sof_d    = s1_sof_q;
      s2_eof_d    = s1_eof_q;
      p_ac_d      = PW'(s1_a_q) * PW'(s1_c_q);
      p_bd_d      = PW'(s1_b_q) * PW'(s1_d_q);
      p_ad_d      = PW'(s1_a_q) * PW'(s1_d_q);
      p_bc_d      = PW'(s1_b_q) * PW'(s1_c_q);

      sum_re      = FW'(p_ac_q) - FW'(p_bd_q) + RndAdd;
      sum_im      = FW'(p_ad_q) + FW'(p_bc_q) + RndAdd;
      lim_re      = limit(sum_re);
      lim_im      = limit(sum_im);
      out_valid_d = s2_valid_q;
      out_sof_d   = s2_valid_q & s2_sof_q;
      out_eof_d   = s2_valid_q & s2_eof_q;
      out_data_d  = s2_valid_q ? {lim_re[DW-1:0], lim_im[DW-1:0]} : out_data_q;
      ovf_d       = ovf_q | (s2_valid_q & (lim_re[DW] | lim_im[DW]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_sof_q    <= 1'b0;
         s2_eof_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         out_data_q  <= '0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sof_q    <= s1_sof_d;
         s1_eof_q    <= s1_eof_d;
         s2_valid_q  <= s2_valid_d;
         s2_sof_q    <= s2_sof_d;
         s2_eof_q    <= s2_eof_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         out_data_q  <= out_data_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
      end
   end

   // Datapath operands carry no reset; their valids gate every use.
   always_ff @(posedge clk) begin
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_c_q <= s1_c_d;
      s1_d_q <= s1_d_d;
      p_ac_q <= p_ac_d;
      p_bd_q <= p_bd_d;
      p_ad_q <= p_ad_d;
      p_bc_q <= p_bc_d;
   end

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_eof   = out_eof_q;
   assign out_data  = out_data_q;
   assign frame_err = frame_err_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_twiddle_cmult.sv
// Scoreboard bench for twiddle_cmult: integer reference model feeds a queue, monitor pops on out_valid.
module tb_twiddle_cmult;

   localparam int DW   = 16;
   localparam int CW   = 11;
   localparam int SIZE = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_sof;
   logic [2*DW-1:0] in_data;
   logic [2*CW-1:0] coeff_in;
   logic            out_valid, out_sof, out_eof, frame_err, ovf;
   logic [2*DW-1:0] out_data;

   twiddle_cmult #(.DW(DW), .CW(CW), .SIZE(SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .coeff_in  (coeff_in),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .out_data  (out_data),
      .frame_err (frame_err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit sof;
      bit eof;
      int re;
      int im;
      bit ovf;
      int due;
   } exp_t;

   exp_t sbq[$];
   bit   in_frame;
   int   pos;
   bit   exp_ferr;
   bit   exp_ovf_mon;
   int   errors = 0;
   int   checks = 0;

   function automatic void chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endfunction

   // Reference: round half up at Q(CW-2), then saturate or wrap to DW bits.
   function automatic void lim(input longint p, output int res, output bit o);
      longint        r, maxv, minv;
      logic [63:0]   rb;
      logic [DW-1:0] lo;
      r    = (p + (longint'(1) <<< (CW - 3))) >>> (CW - 2);
      maxv = (longint'(1) <<< (DW - 1)) - 1;
      minv = -maxv - 1;
      o    = (r > maxv) || (r < minv);
`ifdef CMULT_SAT_EN
      if (r > maxv) r = maxv;
      else if (r < minv) r = minv;
`endif
      rb  = r;
      lo  = rb[DW-1:0];
      res = int'($signed(lo));
   endfunction

   task automatic send(input bit v, input bit s, input int a, input int b, input int c,
                       input int d);
      logic [DW-1:0] ar, br;
      logic [CW-1:0] cr, dr;
      exp_t          e;
      bit            acc, o1, o2;
      @(negedge clk);
      ar       = a[DW-1:0];
      br       = b[DW-1:0];
      cr       = c[CW-1:0];
      dr       = d[CW-1:0];
      in_valid = v;
      in_sof   = s;
      in_data  = {ar, br};
      coeff_in = {cr, dr};
      acc      = 1'b0;
      if (v) begin
         if (!in_frame && s) begin
            acc = 1'b1;
            pos = 0;
         end else if (in_frame) begin
            acc = 1'b1;
            if (s) begin
               if (pos != 0) exp_ferr = 1'b1;
               pos = 0;
            end
         end
      end
      if (acc) begin
         e.sof = (pos == 0);
         e.eof = (pos == SIZE - 1);
         lim(longint'(a) * c - longint'(b) * d, e.re, o1);
         lim(longint'(a) * d + longint'(b) * c, e.im, o2);
         e.ovf = o1 | o2;
         e.due = cyc + 3;
         sbq.push_back(e);
         if (e.eof) begin
            in_frame = 1'b0;
            pos      = 0;
         end else begin
            in_frame = 1'b1;
            pos++;
         end
      end
   endtask

   task automatic send_rand(input bit v, input bit s);
      send(v, s, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_state();
      chk("rst out_valid", out_valid, 0);
      chk("rst out_sof", out_sof, 0);
      chk("rst out_eof", out_eof, 0);
      chk("rst out_data", out_data, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst ovf", ovf, 0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      sbq.delete();
      in_frame = 1'b0;
      pos      = 0;
      exp_ferr = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      check_reset_state();
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            exp_ovf_mon = 1'b0;
            chk("out_valid during rst", out_valid, 0);
         end else if (out_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected out_valid", 1, 0);
            end else begin
               e           = sbq.pop_front();
               exp_ovf_mon = exp_ovf_mon | e.ovf;
               chk("out re", longint'($signed(out_data[2*DW-1:DW])), e.re);
               chk("out im", longint'($signed(out_data[DW-1:0])), e.im);
               chk("out_sof", out_sof, e.sof);
               chk("out_eof", out_eof, e.eof);
               chk("latency cycle", cyc, e.due);
               chk("ovf sticky", ovf, exp_ovf_mon);
            end
         end else begin
            chk("sof/eof without valid", {out_sof, out_eof}, 0);
         end
      end
   end

   initial begin
      int w;
      bit s;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_sof      = 1'b0;
      in_data     = '0;
      coeff_in    = '0;
      in_frame    = 1'b0;
      pos         = 0;
      exp_ferr    = 1'b0;
      exp_ovf_mon = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state();

      // Directed vectors as the head of a full frame
      send(1, 1, 1000, -2000, 512, 0);
      send(1, 0, 1000, -2000, 0, 512);
      send(1, 0, 1, 0, 256, 0);
      send(1, 0, -1, 0, 256, 0);
      send(1, 0, -32768, -32768, -1024, 0);
      for (int i = 5; i < SIZE; i++) send_rand(1, 0);
      idle(4);
      chk("ovf after saturating vector", ovf, 1);
      // Valid without sof while idle is dropped
      for (int i = 0; i < 5; i++) send_rand(1, 0);
      idle(5);

      do_reset(2);
      for (int i = 0; i < 10; i++) send_rand(1, i == 0);
      for (int i = 0; i < SIZE; i++) send_rand(1, i == 0);
      idle(5);
      chk("frame_err after mid-frame sof", frame_err, exp_ferr);

      do_reset(2);
      for (int i = 0; i < 800; i++) begin
         s = in_frame ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
         send_rand($urandom_range(0, 7) != 0, s);
      end
      idle(5);
      chk("frame_err random phase", frame_err, exp_ferr);

      // Reset one cycle after two accepted samples
      do_reset(2);
      send_rand(1, 1);
      send_rand(1, 0);
      do_reset(2);
      idle(8);
      check_reset_state();

      w = 0;
      while (sbq.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
